// File: rtl/gf32_mult_serial.sv
// Iterative GF(2^32) multiplier over P(x) = x^32 + x^7 + x^3 + x^2 + 1.
// Processes BPC multiplier bits per cycle, LSB-first, using repeated xtime of the multiplicand.
module gf32_mult_serial #(
    parameter int BPC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_c,
    output logic        busy,
    output logic [1:0]  dbg_state
);
    localparam int          N    = 32 / BPC;
    localparam int          CW   = $clog2(N) + 1;
    localparam logic [31:0] RED  = 32'h0000_008D;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8)) begin : g_bad_bpc
        $error("gf32_mult_serial: BPC must be 1, 2, 4 or 8");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [31:0]   r_a;
    logic [31:0]   r_b;
    logic [31:0]   r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_busy;

    logic [31:0]   w_a_nxt;
    logic [31:0]   w_acc_nxt;
    logic [31:0]   w_b_nxt;

    function automatic logic [31:0] xtime(input logic [31:0] x);
        return {x[30:0], 1'b0} ^ (x[31] ? RED : 32'h0);
    endfunction

    // One BUSY cycle: BPC accumulate/xtime steps chained in bit order j = 0..BPC-1.
    always_comb begin
        w_acc_nxt = r_acc;
        w_a_nxt   = r_a;
        for (int j = 0; j < BPC; j++) begin
            if (r_b[j]) begin
                w_acc_nxt = w_acc_nxt ^ w_a_nxt;
            end
            w_a_nxt = xtime(w_a_nxt);
        end
    end

    assign w_b_nxt = r_b >> BPC;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
    // in_valid/in_a/in_b are only looked at in IDLE; out_valid/out_c stay fixed in DONE until out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= 32'h0;
            r_b         <= 32'h0;
            r_acc       <= 32'h0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_acc      <= 32'h0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_a   <= w_a_nxt;
                    r_b   <= w_b_nxt;
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_c     = r_acc;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: doc/gf32_mult_serial.md
# gf32_mult_serial

Iterative GF(2^32) multiplier that consumes the multiply-by-x (xtime) stage and applies it repeatedly to form a full field product c = a·b. It works modulo P(x) = x^32 + x^7 + x^3 + x^2 + 1, with reduction constant 0x0000008D. It sits downstream of the xtime stage in the white-box LFSR/mixing datapath and has valid/ready handshakes on both sides. It trades latency for area by processing BPC multiplier bits per clock.

## Interface
- BPC, default 1: multiplier bits processed per cycle. Legal values are 1, 2, 4, 8; any other value is a configuration error.
- clk  input  1: single clock, rising-edge.
- rst  input  1: synchronous, active-high reset.
- in_valid  input  1: operands a and b are valid.
- in_ready  output  1: block can accept operands.
- in_a  input  32: multiplicand, polynomial basis, bit i = coefficient of x^i.
- in_b  input  32: multiplier, same encoding.
- out_valid  output  1: the value on out_c is the finished product.
- out_ready  input  1: the consumer accepts out_c.
- out_c  output  32: a·b mod P(x).
- busy  output  1: high in the BUSY state.

## Operation
- Registers:
  - A (32 bits): running multiplicand.
  - B (32 bits): remaining multiplier, shifted right.
  - ACC (32 bits): partial product.
  - CNT: step counter, log2(32/BPC)+1 bits.
  - state.
- The xtime function is exactly: y = {x[30:0],1'b0} ^ (x[31] ? 32'h0000008D : 0).
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready: A←in_a, B←in_b, ACC←0, CNT←0, go to BUSY.
  - BUSY: each cycle performs BPC inner steps, in order j=0..BPC-1, as one combinational chain:
    - ACC ^= B[j] ? A : 0;
    - then A ← xtime(A).
    - After the chain, B ← B >> BPC and CNT ← CNT+1.
    - When CNT reaches 32/BPC−1, this last step completes and the state moves to DONE.
  - DONE: out_valid=1 and out_c=ACC, both held stable. On out_ready, go to IDLE.
- in_ready is low in BUSY and DONE. Operand changes while not ready are ignored.
- There is no early termination. The block always runs the full 32/BPC steps, so latency does not depend on the data.
- The bit order is LSB-first on B. The result must be bit-exact with a software reference: 32 iterations of (if b&1: acc^=a; a=xtime(a); b>>=1).

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_c=0, busy=0.
  - state=IDLE; A, B, ACC and CNT are all 0.
- Reset mid-operation (in BUSY or DONE) aborts the operation. The next cycle presents the reset values, and no out_valid pulse is produced for the aborted operation.
- Latency: with N = 32/BPC, out_valid rises N cycles after the edge that accepted the operands.
  - BPC=1 → 32; BPC=2 → 16; BPC=4 → 8; BPC=8 → 4.
- Throughput: one product per N+2 cycles when out_ready is held high. This is accept edge, then N BUSY cycles, then one DONE cycle, then return to IDLE.
- Backpressure: DONE holds out_c and out_valid indefinitely until out_ready=1. in_ready stays 0 throughout.
- A handshake completes on a rising edge where valid&&ready=1. out_valid drops on the edge following the out_ready handshake, and in_ready rises on that same edge.
- in_valid arriving during BUSY or DONE is not accepted. The upstream block must hold it until in_ready=1.
- out_c is registered directly from ACC, with no combinational path from inputs to outputs.

## Test plan
- Identity and zero:
  - a=0x00000001, b=0x12345678 → out_c=0x12345678.
  - a=0xDEADBEEF, b=0 → out_c=0x00000000.
  - Each result appears exactly 32 cycles after accept (BPC=1).
- Reduction:
  - a=0x80000000, b=0x00000002 → out_c=0x0000008D.
  - a=0x80000000, b=0x80000000 → out_c=0x40001037.
- Random and commutativity: 1000 random pairs, checked against the software model.
  - a·b must equal b·a.
  - Repeat for BPC=1, 2, 4, 8, checking latency 32/16/8/4 respectively.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - out_c stays stable and in_ready stays 0.
  - On release the handshake completes and in_ready=1 the next cycle.
  - in_valid held high during this window is accepted only then.
- Back-to-back: in_valid and out_ready held high for 5 operations → one accept every 34 cycles (BPC=1), with results in order.
- Reset mid-op: assert rst at BUSY step 15 for one cycle.
  - Outputs return to reset values and no out_valid appears.
  - A new operation a=0x00000003, b=0x00000003 then gives out_c=0x00000005.
